// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: glyph table,
// blank pattern and digit-index sizing.
package seg7_pkg;

  // Segment bits are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    return glyph;
  endfunction

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// CPU write path into the display register.
interface seg7_scan_mux_if;
  logic        we;
  logic [31:0] wdata;

  modport master (output we, output wdata);
  modport slave  (input we, input wdata);
endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble-to-glyph conversion with blanking and decimal-point merge.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = {dp, blank ? SEG_OFF : hex2seg(nibble)};
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Channel selector, CPU display register and multiplexed digit scanner with
// frame-synchronous capture, freeze and leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 17,
  parameter int ACTIVE_LOW = 1,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DATA_W    = 4 * DIGITS
) (
  input  logic                     clk,
  input  logic                     rst,
  seg7_scan_mux_if.slave           cpu,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     freeze,
  input  logic                     blank_lz,
  input  logic [DIGITS-1:0]        dp_mask,
  output logic [7:0]               seg_o,
  output logic [DIGITS-1:0]        an_o,
  output logic                     frame_o
);

  localparam int   IDX_W = idx_width(DIGITS);
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [DATA_W-1:0]   cpu_reg;
  logic [DATA_W-1:0]   disp_val_reg;
  logic [SCAN_DIV-1:0] pre_cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                frame_reg;
  logic [7:0]          seg_reg;
  logic [DIGITS-1:0]   an_reg;

  logic [DATA_W-1:0]   src [NUM_CH];
  logic [DATA_W-1:0]   src_sel;
  logic [DIGITS-1:0]   lz_blank;
  logic                tick;
  logic                last;
  logic                boundary;
  logic [IDX_W-1:0]    idx_next;
  logic [3:0]          nibble;
  logic [7:0]          seg_raw;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  // Slice 0 of the probe bus is replaced by the CPU register.
  assign src[0] = cpu_reg;
  generate
    for (genvar gi = 1; gi < NUM_CH; gi++) begin : g_src
      assign src[gi] = ch_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Selects beyond the last channel fall through to zero.
  always_comb begin
    src_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) src_sel = src[k];
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = blank_lz && (disp_val_reg[DATA_W-1:4*gi] == '0);
      end
    end
  endgenerate

  assign tick     = &pre_cnt_reg;
  assign last     = (idx_reg == IDX_W'(DIGITS - 1));
  assign boundary = tick && last;
  assign idx_next = last ? '0 : idx_reg + IDX_W'(1);
  assign nibble   = disp_val_reg[4*idx_reg +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .blank  (lz_blank[idx_reg]),
    .dp     (dp_mask[idx_reg]),
    .seg    (seg_raw)
  );

  assign seg_next = seg_raw ^ {8{POL}};
  assign an_next  = (DIGITS'(1) << idx_reg) ^ {DIGITS{POL}};

  // The capture samples cpu_reg before any write on the same edge lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_reg      <= '0;
      disp_val_reg <= '0;
      pre_cnt_reg  <= '0;
      idx_reg      <= '0;
      frame_reg    <= 1'b0;
      seg_reg      <= {8{POL}};
      an_reg       <= {DIGITS{POL}};
    end else begin
      pre_cnt_reg <= pre_cnt_reg + SCAN_DIV'(1);
      if (cpu.we) cpu_reg <= cpu.wdata[DATA_W-1:0];
      if (tick) idx_reg <= idx_next;
      if (boundary && !freeze) disp_val_reg <= src_sel;
      frame_reg <= boundary && !freeze;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
    end
  end

  assign seg_o   = seg_reg;
  assign an_o    = an_reg;
  assign frame_o = frame_reg;

  logic unused_ch0;
  assign unused_ch0 = ^ch_data[DATA_W-1:0];

  generate
    if (DATA_W < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^cpu.wdata[31:DATA_W];
    end
  endgenerate

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: expected digit slots are queued per
// frame and compared as the scan reaches each digit.
module tb_seg7_scan_mux;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sel;
  logic [31:0]   ch [8];
  logic [255:0]  ch_flat_a;
  logic [191:0]  ch_flat_b;
  logic          freeze;
  logic          blank_lz;
  logic [7:0]    dp_mask;
  logic [7:0]    seg_a, an_a, seg_b, an_b;
  logic          frame_a, frame_b;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan_mux_if cpu_bus ();

  assign ch_flat_a = {ch[7], ch[6], ch[5], ch[4], ch[3], ch[2], ch[1], ch[0]};
  assign ch_flat_b = {ch[5], ch[4], ch[3], ch[2], ch[1], ch[0]};

  seg7_scan_mux #(.NUM_CH(8), .DIGITS(8), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .cpu(cpu_bus.slave), .sel(sel), .ch_data(ch_flat_a),
    .freeze(freeze), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .seg_o(seg_a), .an_o(an_a), .frame_o(frame_a)
  );

  seg7_scan_mux #(.NUM_CH(6), .DIGITS(8), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .cpu(cpu_bus.slave), .sel(sel), .ch_data(ch_flat_b),
    .freeze(freeze), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .seg_o(seg_b), .an_o(an_b), .frame_o(frame_b)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
      4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
      4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
      4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Expected active-low segment byte for digit i of value v.
  function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic blz,
                                         input logic [7:0] dpm, input int i);
    logic [3:0] nib;
    logic       bl;
    nib = 4'((v >> (4 * i)) & 32'hF);
    bl  = blz && (i > 0) && ((v >> (4 * i)) == 32'h0);
    return ~{dpm[i], bl ? 7'h00 : glyph(nib)};
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic blz, input logic [7:0] dpm);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.an  = ~(8'h01 << i);
      e.seg = exp_seg(v, blz, dpm, i);
      sb.push_back(e);
    end
  endtask

  // Waits for the next capture pulse, then samples the middle of each digit
  // slot. Optionally rewrites ch[3] once the scan reaches chg_digit.
  task automatic capture(input bit use_b, input string tag, input int chg_digit,
                         input logic [31:0] chg_val);
    int   waited;
    exp_t e;
    logic [7:0] an_s, seg_s;
    waited = 0;
    while (!(use_b ? frame_b : frame_a) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!(use_b ? frame_b : frame_a)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s frame_timeout: got no frame_o after %0d cycles, required one pulse", tag, waited);
      sb.delete();
      return;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      if (sb.size() == 0) break;
      e     = sb.pop_front();
      an_s  = use_b ? an_b : an_a;
      seg_s = use_b ? seg_b : seg_a;
      n_cmp++;
      if (an_s !== e.an) begin
        n_fail++;
        $display("FAIL %s an d%0d: got %h required %h", tag, d, an_s, e.an);
      end
      n_cmp++;
      if (seg_s !== e.seg) begin
        n_fail++;
        $display("FAIL %s seg d%0d: got %h required %h", tag, d, seg_s, e.seg);
      end
      $display("%s digit %0d an=%h seg=%h (exp an=%h seg=%h)", tag, d, an_s, seg_s, e.an, e.seg);
      if (d < 7) begin
        if (d == chg_digit - 1) begin
          repeat (2) @(negedge clk);
          ch[3] = chg_val;
          repeat (2) @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
      end
    end
  endtask

  task automatic count_frames(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (frame_a) cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 3'd0; freeze = 1'b0; blank_lz = 1'b0; dp_mask = 8'h00;
    cpu_bus.we = 1'b0; cpu_bus.wdata = 32'h0;
    for (int k = 0; k < 8; k++) ch[k] = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (an_a !== 8'hFF) begin n_fail++; $display("FAIL reset an: got %h required ff", an_a); end
    n_cmp++; if (seg_a !== 8'hFF) begin n_fail++; $display("FAIL reset seg: got %h required ff", seg_a); end
    rst = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (an_a !== 8'hFF || seg_a !== 8'hFF) begin
      n_fail++; $display("FAIL midscan_reset: got an=%h seg=%h required ff/ff", an_a, seg_a);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (an_a !== 8'hFE || seg_a !== 8'hC0) begin
      n_fail++; $display("FAIL first_out: got an=%h seg=%h required fe/c0", an_a, seg_a);
    end
    $display("reset checks done");
  endtask

  task automatic test_basic();
    cpu_bus.we = 1'b1; cpu_bus.wdata = 32'h1234ABCD;
    @(negedge clk);
    cpu_bus.we = 1'b0;
    push_frame(32'h1234ABCD, 1'b0, 8'h00);
    capture(1'b0, "basic", -1, 32'h0);
  endtask

  task automatic test_select();
    ch[3] = 32'h00000042; sel = 3'd3;
    push_frame(32'h00000042, 1'b0, 8'h00);
    capture(1'b0, "sel3", -1, 32'h0);
    ch[7] = 32'hFFFFFFFF; sel = 3'd7;
    push_frame(32'hFFFFFFFF, 1'b0, 8'h00);
    capture(1'b0, "sel7", -1, 32'h0);
    push_frame(32'h0, 1'b0, 8'h00);
    capture(1'b1, "sel_oor", -1, 32'h0);
  endtask

  task automatic test_tear();
    int cnt;
    sel = 3'd3;
    push_frame(32'h00000042, 1'b0, 8'h00);
    capture(1'b0, "tear_old", 4, 32'h0000BEEF);
    push_frame(32'h0000BEEF, 1'b0, 8'h00);
    capture(1'b0, "tear_new", -1, 32'h0);
    count_frames(96, cnt);
    n_cmp++; if (cnt != 3) begin n_fail++; $display("FAIL frame_rate: got %0d pulses required 3", cnt); end
    $display("frame pulses in 96 cycles: %0d", cnt);
  endtask

  task automatic test_freeze();
    int cnt, bad, d;
    freeze = 1'b1;
    ch[3] = 32'h00000077;
    cnt = 0; bad = 0;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      if (frame_a) cnt++;
      d = -1;
      for (int i = 0; i < 8; i++) if (an_a === ~(8'h01 << i)) d = i;
      if (d < 0 || seg_a !== exp_seg(32'h0000BEEF, 1'b0, 8'h00, d)) bad++;
    end
    n_cmp++; if (cnt != 0) begin n_fail++; $display("FAIL freeze_frame: got %0d pulses required 0", cnt); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL freeze_hold: got %0d changed slots required 0", bad); end
    $display("freeze: pulses=%0d changed_slots=%0d", cnt, bad);
    freeze = 1'b0;
    push_frame(32'h00000077, 1'b0, 8'h00);
    capture(1'b0, "unfreeze", -1, 32'h0);
  endtask

  task automatic test_lz();
    ch[3] = 32'h00000120; blank_lz = 1'b1; dp_mask = 8'h02;
    push_frame(32'h00000120, 1'b1, 8'h02);
    capture(1'b0, "lz120", -1, 32'h0);
    ch[3] = 32'h0;
    push_frame(32'h0, 1'b1, 8'h02);
    capture(1'b0, "lz0", -1, 32'h0);
    blank_lz = 1'b0; dp_mask = 8'h00;
  endtask

  task automatic test_back_to_back();
    sel = 3'd0;
    cpu_bus.we = 1'b1; cpu_bus.wdata = 32'h11;
    @(negedge clk);
    cpu_bus.we = 1'b0;
    push_frame(32'h11, 1'b0, 8'h00);
    capture(1'b0, "pre11", -1, 32'h0);
    @(negedge clk);
    cpu_bus.we = 1'b1; cpu_bus.wdata = 32'h55;
    @(negedge clk);
    cpu_bus.we = 1'b0;
    push_frame(32'h11, 1'b0, 8'h00);
    capture(1'b0, "coll_old", -1, 32'h0);
    push_frame(32'h55, 1'b0, 8'h00);
    capture(1'b0, "coll_new", -1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_select();
    test_tear();
    test_freeze();
    test_lz();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
